// File: rtl/jw_ram_sched.sv
// Double-buffered BCD digit store for the jw display field: the producer fills a hidden
// back bank, the banks swap on a frame boundary, then the new back is refreshed from the front.
module jw_ram_sched #(
  parameter int DEPTH = 10,
  parameter int DW    = 4,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_last,
  input  logic          frame_start,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          swap_done,
  output logic          busy,
  output logic          addr_err,
  input  logic          err_clr,
  output logic [2:0]    dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FILL = 3'd1,
    S_PEND = 3'd2,
    S_SWAP = 3'd3,
    S_COPY = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic          front_sel_q, front_sel_d;
  logic [AW-1:0] copy_idx_q, copy_idx_d;
  logic [DW-1:0] rd_data_q;
  logic          addr_err_q;
  logic [DW-1:0] mem_q [2][DEPTH];

  logic wr_fire;
  logic wr_addr_ok;
  logic rd_addr_ok;
  logic back_sel;

  // Handshake: a write transfers on a rising edge with wr_valid && wr_ready; wr_ready
  // depends on state only, so the producer may hold wr_valid/data while it is low.
  assign wr_ready    = (state_q == S_IDLE) || (state_q == S_FILL);
  assign wr_fire     = wr_valid && wr_ready;
  assign wr_addr_ok  = (wr_addr < AW'(DEPTH));
  assign rd_addr_ok  = (rd_addr < AW'(DEPTH));
  assign back_sel    = ~front_sel_q;
  assign swap_done   = (state_q == S_SWAP);
  assign busy        = (state_q != S_IDLE);
  assign rd_data     = rd_data_q;
  assign addr_err    = addr_err_q;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d     = state_q;
    front_sel_d = front_sel_q;
    copy_idx_d  = copy_idx_q;
    case (state_q)
      S_IDLE, S_FILL: begin
        if (wr_fire) state_d = wr_last ? S_PEND : S_FILL;
      end
      S_PEND: begin
        if (frame_start) state_d = S_SWAP;
      end
      S_SWAP: begin
        front_sel_d = ~front_sel_q;
        copy_idx_d  = '0;
        state_d     = S_COPY;
      end
      S_COPY: begin
        copy_idx_d = copy_idx_q + AW'(1);
        if (copy_idx_q == AW'(DEPTH - 1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      front_sel_q <= 1'b0;
      copy_idx_q  <= '0;
      rd_data_q   <= '0;
      addr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      front_sel_q <= front_sel_d;
      copy_idx_q  <= copy_idx_d;
      rd_data_q   <= rd_addr_ok ? mem_q[front_sel_q][rd_addr] : '0;
      // A new error outranks a clear in the same cycle.
      if (wr_fire && !wr_addr_ok) addr_err_q <= 1'b1;
      else if (err_clr)           addr_err_q <= 1'b0;
    end
  end

  // Copy and producer writes never overlap: wr_ready is low throughout COPY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem_q[b][i] <= '0;
        end
      end
    end else if (state_q == S_COPY) begin
      mem_q[back_sel][copy_idx_q] <= mem_q[front_sel_q][copy_idx_q];
    end else if (wr_fire && wr_addr_ok) begin
      mem_q[back_sel][wr_addr] <= wr_data;
    end
  end

endmodule

// File: doc/jw_ram_sched.md
# jw_ram_sched

Double-buffered digit store and update scheduler for the longitude/latitude ("jw") display field. A producer (the GPS/position formatter) writes a packet of BCD digits into a hidden back bank through a valid/ready handshake. The display path reads the visible front bank through the column/row address map. Banks swap only at a frame boundary, so a field is never shown half-updated.

## Interface

Parameters:
- `DEPTH`, default 10: number of digit slots, addressed 0..DEPTH-1. Slots 0-4 are row group 1 and slots 5-9 are row group 2.
- `DW`, default 4: digit width in bits (BCD).
- `AW`, default 4: address width.

Ports:
- `clk`, in, 1: system clock. The block has one clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `wr_valid`, in, 1: producer has a digit write.
- `wr_ready`, out, 1: block accepts a write this cycle.
- `wr_addr`, in, AW: target slot.
- `wr_data`, in, DW: digit value.
- `wr_last`, in, 1: marks the final write of a packet; qualified by the handshake.
- `frame_start`, in, 1: one-cycle pulse at the start of each display frame.
- `rd_addr`, in, AW: slot address from the display address map.
- `rd_data`, out, DW: registered front-bank digit.
- `swap_done`, out, 1: one-cycle pulse when the banks swap.
- `busy`, out, 1: high whenever the state is not IDLE.
- `addr_err`, out, 1: sticky flag, set when a write is accepted with `wr_addr` >= DEPTH.
- `err_clr`, in, 1: synchronous clear of `addr_err`.

## Operation

Storage and bank select:
- Two banks, each DEPTH x DW.
- `front_sel` selects the displayed bank. The back bank is always `!front_sel`.

State machine, states IDLE, FILL, PEND, SWAP, COPY:
- **IDLE:**
  - `wr_ready`=1.
  - An accepted write goes to the back bank.
  - If `wr_last`=1 on that write, next state is PEND; otherwise next state is FILL.
- **FILL:**
  - `wr_ready`=1.
  - Accepted writes go to the back bank.
  - An accepted write with `wr_last`=1 moves to PEND.
  - `frame_start` is ignored in FILL.
- **PEND:**
  - `wr_ready`=0.
  - Waits for `frame_start`; when it is sampled, next state is SWAP.
- **SWAP** (one cycle):
  - `swap_done`=1.
  - `front_sel` toggles at the end of this cycle.
  - `copy_idx` is cleared to 0.
- **COPY** (DEPTH cycles):
  - `wr_ready`=0.
  - Each cycle, new-front[`copy_idx`] is copied to new-back[`copy_idx`] and `copy_idx` increments.
  - After `copy_idx`=DEPTH-1, next state is IDLE.
  - This makes the back bank mirror the front, so a later partial packet updates only the digits it writes.

Write and read rules:
- An accepted write with `wr_addr` >= DEPTH does not modify storage and sets `addr_err`. Its `wr_last` is still honoured.
- Read: `rd_data` <= front[`rd_addr`] on every clock. `rd_addr` >= DEPTH returns 0.
- Duplicate writes to the same slot within one packet: the last write wins.

Flag priority:
- `err_clr` and a new error in the same cycle: the set wins.

## Timing

- Reset values (`rst_n`=0, effective immediately):
  - state=IDLE, `front_sel`=0, both banks all-zero, `copy_idx`=0.
  - `rd_data`=0, `swap_done`=0, `addr_err`=0, `busy`=0.
  - `wr_ready`=1 after reset release.
- Reset mid-operation (any state): same values. A partly written packet is discarded.
- Write handshake:
  - A transfer occurs on a rising edge where `wr_valid` && `wr_ready`.
  - `wr_ready` is combinational from state only, never from `wr_valid`.
- Read latency: 1 cycle from `rd_addr` to `rd_data`.
- Read in the cycle after SWAP returns the new front bank.
- Swap latency:
  - `frame_start` sampled in PEND at edge N gives SWAP during cycle N+1.
  - The new bank is visible on `rd_data` for `rd_addr` presented from cycle N+2.
- Block returns to IDLE DEPTH+1 cycles after leaving PEND. `wr_ready` is 0 for that whole span plus the PEND time.
- Accepted `wr_last` and `frame_start` in the same cycle: the state moves to PEND. That `frame_start` does not trigger a swap; the swap waits for the next pulse.
- `frame_start` during SWAP or COPY: ignored. No queued swap.
- `wr_valid` without `wr_ready` (PEND/SWAP/COPY): no effect. The producer must hold its data until ready.

## Test plan

- **Reset:** assert `rst_n`=0 mid-COPY.
  - Required: `busy`=0, `rd_data`=0 for all `rd_addr`, `wr_ready`=1 after release.
- **Full packet:**
  - Stimulus: write digits 1..9,0 to slots 0..9 with `wr_last` on slot 9, then pulse `frame_start`.
  - Required: `rd_data` stays 0 until the swap. `swap_done` pulses exactly once. `rd_addr`=3 then reads 4. `busy` drops after 11 cycles.
- **Partial update after copy:**
  - Stimulus: following the full packet, write slot 5 = 7 with `wr_last`, then pulse `frame_start`.
  - Required: slot 5 reads 7; every other slot is unchanged (slot 0 reads 1).
- **Bad address:**
  - Stimulus: accepted write to `wr_addr`=12 with `wr_last`.
  - Required: `addr_err`=1, no storage change, state PEND. `err_clr` then clears the flag.
- **Coincident events:**
  - Stimulus: `wr_last` and `frame_start` in the same cycle.
  - Required: no swap. The next `frame_start` swaps. `frame_start` during COPY is ignored.
- **Backpressure:**
  - Stimulus: hold `wr_valid`=1 through PEND/SWAP/COPY.
  - Required: `wr_ready`=0 throughout, and the held write is accepted on the first IDLE cycle.
